ntt_stage_scheduler: RTL

//  Sequences a dit_butterfly over an N-point in-place radix-2 DIT NTT held in a dual-port coefficient RAM.

---
 rtl/ntt_stage_scheduler_pkg.sv | 15 +
 rtl/ntt_stage_scheduler_wb.sv | 27 ++
 rtl/ntt_stage_scheduler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ntt_stage_scheduler_pkg.sv
// Shared constants for the NTT stage scheduler: multiplier/reducer pipeline
// depths (which set the butterfly latency) and FSM state encodings.
package ntt_stage_scheduler_pkg;

    localparam int INTMUL_DELAY = 3;
    localparam int MODRED_DELAY = 2;

    localparam logic [2:0] NTT_IDLE   = 3'd0;
    localparam logic [2:0] NTT_BFLY   = 3'd1;
    localparam logic [2:0] NTT_DRAIN  = 3'd2;
    localparam logic [2:0] NTT_SCALE  = 3'd3;
    localparam logic [2:0] NTT_SDRAIN = 3'd4;
    localparam logic [2:0] NTT_DONE   = 3'd5;

endpackage

// File: rtl/ntt_stage_scheduler_wb.sv
// Fixed-depth shift line carrying issue-time write-back info (valid/mode/addrs)
// across the RAM read plus butterfly latency; fully cleared on reset.
module ntt_wb_delay #(
    parameter int DEPTH = 7,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] d_out
);

    logic [DEPTH-1:0][W-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d[0] = d_in;
        for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (!reset) pipe_q <= '0;
        else        pipe_q <= pipe_d;
    end

    assign d_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_scheduler.sv
// Issues one radix-2 DIT butterfly (or scale multiply) per cycle over an in-place
// coefficient RAM and delay-matches the write-back to the butterfly latency.
module ntt_stage_scheduler
    import ntt_stage_scheduler_pkg::*;
#(
    parameter int LOGN          = 8,
    parameter int RD_LAT        = 1,
    parameter int BF_LAT        = INTMUL_DELAY + MODRED_DELAY + 1,
    parameter int TW_SCALE_ADDR = (1 << LOGN) - 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [LOGN:0]   num_stages,
    input  logic            scale_en,
    output logic            busy,
    output logic            done,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [LOGN-1:0] tw_addr,
    output logic            bf_mode,
    output logic            wr_en_a,
    output logic            wr_en_b,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b
);

    localparam int N  = 1 << LOGN;
    localparam int D  = RD_LAT + BF_LAT;
    localparam int DW = $clog2(D + 1);
    localparam logic [LOGN-1:0] HALF_LAST = LOGN'(N/2 - 1);
    localparam logic [LOGN-1:0] FULL_LAST = LOGN'(N - 1);
    localparam logic [LOGN-1:0] TOP_SH    = LOGN'(LOGN - 1);
    localparam logic [LOGN:0]   MAX_STG   = (LOGN+1)'(LOGN);

    logic [2:0]      state_q, state_d;
    logic [LOGN-1:0] cnt_q, cnt_d;
    logic [LOGN-1:0] stage_q, stage_d;
    logic [LOGN:0]   nstg_q, nstg_d;
    logic            scl_q, scl_d;
    logic [DW-1:0]   drn_q, drn_d;
    logic            iss_vld_q, iss_vld_d;
    logic            iss_mode_q, iss_mode_d;
    logic [LOGN-1:0] rd_addr_a_q, rd_addr_a_d;
    logic [LOGN-1:0] rd_addr_b_q, rd_addr_b_d;
    logic [LOGN-1:0] tw_addr_q, tw_addr_d;
    logic            done_q, done_d;

    logic [LOGN-1:0] half, idx, grp, bf_a, bf_b, bf_tw;
    logic [LOGN:0]   ns_clamped, stage_nxt;

    // Stage s pairs j with partner half away: a = grp*2*half + idx, b = a + half.
    assign half      = LOGN'(1) << stage_q;
    assign idx       = cnt_q & (half - LOGN'(1));
    assign grp       = cnt_q >> stage_q;
    assign bf_a      = (grp << (stage_q + LOGN'(1))) | idx;
    assign bf_b      = bf_a | half;
    assign bf_tw     = idx << (TOP_SH - stage_q);
    assign ns_clamped = (num_stages > MAX_STG) ? MAX_STG : num_stages;
    assign stage_nxt = {1'b0, stage_q} + (LOGN+1)'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stage_d     = stage_q;
        nstg_d      = nstg_q;
        scl_d       = scl_q;
        drn_d       = drn_q;
        iss_vld_d   = 1'b0;
        iss_mode_d  = 1'b0;
        rd_addr_a_d = '0;
        rd_addr_b_d = '0;
        tw_addr_d   = '0;
        done_d      = (state_q == NTT_DONE);
        case (state_q)
            NTT_IDLE: if (start) begin
                nstg_d  = ns_clamped;
                scl_d   = scale_en;
                stage_d = '0;
                cnt_d   = '0;
                if (ns_clamped != '0) state_d = NTT_BFLY;
                else if (scale_en)    state_d = NTT_SCALE;
                else                  state_d = NTT_DONE;
            end
            NTT_BFLY: begin
                iss_vld_d   = 1'b1;
                rd_addr_a_d = bf_a;
                rd_addr_b_d = bf_b;
                tw_addr_d   = bf_tw;
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    drn_d   = '0;
                    state_d = NTT_DRAIN;
                end else begin
                    cnt_d = cnt_q + LOGN'(1);
                end
            end
            NTT_DRAIN: begin
                if (drn_q == DW'(D - 1)) begin
                    if (stage_nxt < nstg_q) begin
                        stage_d = stage_nxt[LOGN-1:0];
                        state_d = NTT_BFLY;
                    end else if (scl_q) begin
                        state_d = NTT_SCALE;
                    end else begin
                        state_d = NTT_DONE;
                    end
                end else begin
                    drn_d = drn_q + DW'(1);
                end
            end
            NTT_SCALE: begin
                iss_vld_d   = 1'b1;
                iss_mode_d  = 1'b1;
                rd_addr_a_d = cnt_q;
                rd_addr_b_d = cnt_q;
                tw_addr_d   = LOGN'(TW_SCALE_ADDR);
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    drn_d   = '0;
                    state_d = NTT_SDRAIN;
                end else begin
                    cnt_d = cnt_q + LOGN'(1);
                end
            end
            NTT_SDRAIN: begin
                if (drn_q == DW'(D - 1)) state_d = NTT_DONE;
                else                     drn_d   = drn_q + DW'(1);
            end
            NTT_DONE: state_d = NTT_IDLE;
            default:  state_d = NTT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= NTT_IDLE;
            cnt_q       <= '0;
            stage_q     <= '0;
            nstg_q      <= '0;
            scl_q       <= 1'b0;
            drn_q       <= '0;
            iss_vld_q   <= 1'b0;
            iss_mode_q  <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            tw_addr_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            nstg_q      <= nstg_d;
            scl_q       <= scl_d;
            drn_q       <= drn_d;
            iss_vld_q   <= iss_vld_d;
            iss_mode_q  <= iss_mode_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            tw_addr_q   <= tw_addr_d;
            done_q      <= done_d;
        end
    end

    logic [2*LOGN+1:0] wb_in, wb_out;
    logic              wb_vld, wb_mode;

    assign wb_in = {iss_vld_q, iss_mode_q, rd_addr_a_q, rd_addr_b_q};

    ntt_wb_delay #(.DEPTH(D), .W(2*LOGN+2)) u_wb (
        .clk   (clk),
        .reset (reset),
        .d_in  (wb_in),
        .d_out (wb_out)
    );

    ntt_wb_delay #(.DEPTH(RD_LAT), .W(1)) u_mode (
        .clk   (clk),
        .reset (reset),
        .d_in  (iss_mode_q),
        .d_out (bf_mode)
    );

    assign {wb_vld, wb_mode, wr_addr_a, wr_addr_b} = wb_out;
    assign wr_en_a   = wb_vld;
    assign wr_en_b   = wb_vld & ~wb_mode;
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign tw_addr   = tw_addr_q;
    assign busy      = (state_q != NTT_IDLE);
    assign done      = done_q;

endmodule
